// File: rtl/fluxo_dados_pkg.sv
// Shared constants for the memory-game datapath:
// colour codes, default depth and the power-on sequence.
package fluxo_dados_pkg;

   typedef logic [3:0] cor_t;

   localparam cor_t VERMELHO = 4'b0001;
   localparam cor_t VERDE    = 4'b0010;
   localparam cor_t AZUL     = 4'b0100;
   localparam cor_t AMARELO  = 4'b1000;

   localparam int DEPTH_PADRAO = 16;

   // Entry i lives in bits [4*i +: 4]; entry 0 is the low nibble.
   localparam logic [63:0] SEQ_INICIAL = 64'h1824_8142_8418_2421;

   function automatic cor_t seq_inicial(input int i);
      return SEQ_INICIAL[(i % 16) * 4 +: 4];
   endfunction

endpackage

// File: rtl/fluxo_dados_if.sv
// Command strobes from the game FSM and the
// status flags returned by the datapath.
interface fluxo_dados_if;

   logic zera_endereco, conta_endereco;
   logic zera_limite, conta_limite;
   logic zeraR, registrarR;
   logic zera_modo, registra_modo;
   logic zera_s_timeout, enable_timeout;
   logic zera_s_led, enable_led;
   logic registra_jogada, conf_leds;

   logic jogada, igual;
   logic enderecoIgualLimite, fim_sequencia;
   logic fim_jogo, timeout, timeout_led;
   logic timeout_habilitado;

   modport master (
      output zera_endereco, conta_endereco,
      output zera_limite, conta_limite,
      output zeraR, registrarR,
      output zera_modo, registra_modo,
      output zera_s_timeout, enable_timeout,
      output zera_s_led, enable_led,
      output registra_jogada, conf_leds,
      input  jogada, igual,
      input  enderecoIgualLimite, fim_sequencia,
      input  fim_jogo, timeout, timeout_led,
      input  timeout_habilitado
   );

   modport slave (
      input  zera_endereco, conta_endereco,
      input  zera_limite, conta_limite,
      input  zeraR, registrarR,
      input  zera_modo, registra_modo,
      input  zera_s_timeout, enable_timeout,
      input  zera_s_led, enable_led,
      input  registra_jogada, conf_leds,
      output jogada, igual,
      output enderecoIgualLimite, fim_sequencia,
      output fim_jogo, timeout, timeout_led,
      output timeout_habilitado
   );

endinterface

// File: rtl/contador_m.sv
// Mod-M counter with clear priority; at the terminal
// count it either wraps to zero or saturates.
module contador_m #(
   parameter int M      = 16,
   parameter bit SATURA = 1'b0,
   localparam int W     = (M > 1) ? $clog2(M) : 1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         zera_i,
   input  logic         conta_i,
   output logic [W-1:0] q_o,
   output logic         fim_o
);

   logic [W-1:0] cnt_q, cnt_d;

   assign fim_o = (cnt_q == W'(M - 1));
   assign q_o   = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (zera_i)
         cnt_d = '0;
      else if (conta_i) begin
         if (fim_o)
            cnt_d = SATURA ? cnt_q : '0;
         else
            cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/fluxo_dados.sv
// Memory-game datapath: sequence memory, counters, timers,
// move/mode registers and the button edge detector.
module fluxo_dados
   import fluxo_dados_pkg::*;
#(
   parameter int DEPTH     = DEPTH_PADRAO,
   parameter int M_TIMEOUT = 5000,
   parameter int M_LED     = 1000
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [3:0]    botoes,
   input  logic          chave_timeout,
   fluxo_dados_if.slave  bus,
   output logic [3:0]    leds,
   output logic [3:0]    db_endereco,
   output logic [3:0]    db_limite,
   output logic [3:0]    db_jogada,
   output logic [3:0]    db_memoria
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(M_TIMEOUT);
   localparam int LW = $clog2(M_LED);

   logic [AW-1:0] endereco, limite;
   logic [TW-1:0] tmo_cnt;
   logic [LW-1:0] led_cnt;
   logic          end_fim, lim_fim;

   cor_t botoes_meta_q, botoes_sync_q, botoes_ant_q;
   cor_t reg_jogada_q;
   logic jogada_q, modo_q;
   cor_t mem_q [DEPTH];
   cor_t mem_rd;

   contador_m #(.M(DEPTH), .SATURA(1'b0)) u_endereco (
      .clock, .reset,
      .zera_i (bus.zera_endereco),
      .conta_i(bus.conta_endereco),
      .q_o    (endereco),
      .fim_o  (end_fim)
   );

   contador_m #(.M(DEPTH), .SATURA(1'b0)) u_limite (
      .clock, .reset,
      .zera_i (bus.zera_limite),
      .conta_i(bus.conta_limite),
      .q_o    (limite),
      .fim_o  (lim_fim)
   );

   contador_m #(.M(M_TIMEOUT), .SATURA(1'b1)) u_tmo (
      .clock, .reset,
      .zera_i (bus.zera_s_timeout),
      .conta_i(bus.enable_timeout),
      .q_o    (tmo_cnt),
      .fim_o  (bus.timeout)
   );

   contador_m #(.M(M_LED), .SATURA(1'b1)) u_led (
      .clock, .reset,
      .zera_i (bus.zera_s_led),
      .conta_i(bus.enable_led),
      .q_o    (led_cnt),
      .fim_o  (bus.timeout_led)
   );

   logic unused_sinais;
   assign unused_sinais = ^{end_fim, tmo_cnt, led_cnt};

   // Two flops to synchronize, a third for edge detection.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         botoes_meta_q <= '0;
         botoes_sync_q <= '0;
         botoes_ant_q  <= '0;
         jogada_q      <= 1'b0;
      end else begin
         botoes_meta_q <= botoes;
         botoes_sync_q <= botoes_meta_q;
         botoes_ant_q  <= botoes_sync_q;
         jogada_q      <= (|botoes_sync_q) & ~(|botoes_ant_q);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         reg_jogada_q <= '0;
         modo_q       <= 1'b0;
      end else begin
         if (bus.zeraR)           reg_jogada_q <= '0;
         else if (bus.registrarR) reg_jogada_q <= botoes_sync_q;
         if (bus.zera_modo)          modo_q <= 1'b0;
         else if (bus.registra_modo) modo_q <= chave_timeout;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= seq_inicial(i);
      end else if (bus.registra_jogada) begin
         mem_q[endereco] <= botoes_sync_q;
      end
   end

   assign mem_rd = mem_q[endereco];

   assign bus.jogada              = jogada_q;
   assign bus.igual               = (reg_jogada_q == mem_rd);
   assign bus.enderecoIgualLimite = (endereco == limite);
   assign bus.fim_sequencia       = (endereco == limite);
   assign bus.fim_jogo            = lim_fim;
   assign bus.timeout_habilitado  = modo_q;

   assign leds        = bus.conf_leds ? mem_rd : 4'b0000;
   assign db_endereco = 4'(endereco);
   assign db_limite   = 4'(limite);
   assign db_jogada   = reg_jogada_q;
   assign db_memoria  = mem_rd;

endmodule

// File: tb/tb_fluxo_dados.sv
// Directed bench for fluxo_dados with short timers
// (M_TIMEOUT=6, M_LED=4).
module tb_fluxo_dados;

   logic       clock;
   logic       reset;
   logic [3:0] botoes;
   logic       chave_timeout;
   logic [3:0] leds, db_endereco, db_limite;
   logic [3:0] db_jogada, db_memoria;
   int         errors;
   int         checks;

   fluxo_dados_if bus();

   fluxo_dados #(
      .DEPTH(16), .M_TIMEOUT(6), .M_LED(4)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .botoes       (botoes),
      .chave_timeout(chave_timeout),
      .bus          (bus),
      .leds         (leds),
      .db_endereco  (db_endereco),
      .db_limite    (db_limite),
      .db_jogada    (db_jogada),
      .db_memoria   (db_memoria)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step(input int n = 1);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic clear_cmds();
      bus.zera_endereco   = 0; bus.conta_endereco = 0;
      bus.zera_limite     = 0; bus.conta_limite   = 0;
      bus.zeraR           = 0; bus.registrarR     = 0;
      bus.zera_modo       = 0; bus.registra_modo  = 0;
      bus.zera_s_timeout  = 0; bus.enable_timeout = 0;
      bus.zera_s_led      = 0; bus.enable_led     = 0;
      bus.registra_jogada = 0; bus.conf_leds      = 0;
   endtask

   task automatic test_reset();
      botoes = 4'b1000;
      step(3);
      bus.registra_jogada = 1; step(); bus.registra_jogada = 0;
      checks++; if (db_memoria !== 4'b1000) begin errors++; $display("FAIL pre_reset_write got=%b exp=1000", db_memoria); end
      bus.conta_endereco = 1; step(2); bus.conta_endereco = 0;
      bus.conta_limite = 1; step(); bus.conta_limite = 0;
      bus.registrarR = 1; step(); bus.registrarR = 0;
      chave_timeout = 1;
      bus.registra_modo = 1; step(); bus.registra_modo = 0;
      bus.enable_timeout = 1; bus.enable_led = 1;
      step(2);
      #2 reset = 1;
      #1;
      checks++; if (db_endereco !== 4'd0) begin errors++; $display("FAIL rst_endereco got=%0d exp=0", db_endereco); end
      checks++; if (db_limite !== 4'd0) begin errors++; $display("FAIL rst_limite got=%0d exp=0", db_limite); end
      checks++; if (db_jogada !== 4'd0) begin errors++; $display("FAIL rst_jogada_reg got=%b exp=0000", db_jogada); end
      checks++; if (db_memoria !== 4'b0001) begin errors++; $display("FAIL rst_memoria got=%b exp=0001", db_memoria); end
      checks++; if (bus.enderecoIgualLimite !== 1'b1) begin errors++; $display("FAIL rst_eil got=%b exp=1", bus.enderecoIgualLimite); end
      checks++; if (bus.fim_sequencia !== 1'b1) begin errors++; $display("FAIL rst_fim_seq got=%b exp=1", bus.fim_sequencia); end
      checks++; if (bus.fim_jogo !== 1'b0) begin errors++; $display("FAIL rst_fim_jogo got=%b exp=0", bus.fim_jogo); end
      checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout got=%b exp=0", bus.timeout); end
      checks++; if (bus.timeout_led !== 1'b0) begin errors++; $display("FAIL rst_timeout_led got=%b exp=0", bus.timeout_led); end
      checks++; if (bus.timeout_habilitado !== 1'b0) begin errors++; $display("FAIL rst_modo got=%b exp=0", bus.timeout_habilitado); end
      checks++; if (bus.igual !== 1'b0) begin errors++; $display("FAIL rst_igual got=%b exp=0", bus.igual); end
      checks++; if (bus.jogada !== 1'b0) begin errors++; $display("FAIL rst_jogada got=%b exp=0", bus.jogada); end
      checks++; if (leds !== 4'b0000) begin errors++; $display("FAIL rst_leds got=%b exp=0000", leds); end
      clear_cmds();
      botoes = 0; chave_timeout = 0;
      @(negedge clock) reset = 0;
      step(4);
      bus.conf_leds = 1; #1;
      checks++; if (leds !== 4'b0001) begin errors++; $display("FAIL leds_conf got=%b exp=0001", leds); end
      bus.conf_leds = 0;
   endtask

   task automatic test_button_edge();
      int pulses;
      int first;
      pulses = 0; first = 0;
      botoes = 4'b0100;
      for (int k = 1; k <= 12; k++) begin
         if (k == 11) botoes = 4'b0000;
         step();
         if (bus.jogada === 1'b1) begin
            pulses++;
            if (first == 0) first = k;
         end
      end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL btn_pulses got=%0d exp=1", pulses); end
      checks++; if (first !== 3) begin errors++; $display("FAIL btn_latency got=%0d exp=3", first); end
      step(3);
      botoes = 4'b0010;
      step(2);
      checks++; if (bus.jogada !== 1'b0) begin errors++; $display("FAIL btn2_early got=%b exp=0", bus.jogada); end
      step();
      checks++; if (bus.jogada !== 1'b1) begin errors++; $display("FAIL btn2_pulse got=%b exp=1", bus.jogada); end
      step();
      checks++; if (bus.jogada !== 1'b0) begin errors++; $display("FAIL btn2_end got=%b exp=0", bus.jogada); end
      botoes = 0;
      step(4);
   endtask

   task automatic test_compare();
      bus.zera_endereco = 1; step(); bus.zera_endereco = 0;
      botoes = 4'b0001; step(3);
      bus.registrarR = 1; step(); bus.registrarR = 0;
      checks++; if (db_jogada !== 4'b0001) begin errors++; $display("FAIL cmp_reg got=%b exp=0001", db_jogada); end
      checks++; if (bus.igual !== 1'b1) begin errors++; $display("FAIL cmp_eq got=%b exp=1", bus.igual); end
      botoes = 4'b0011; step(3);
      bus.registrarR = 1; step(); bus.registrarR = 0;
      checks++; if (db_jogada !== 4'b0011) begin errors++; $display("FAIL cmp_multihot got=%b exp=0011", db_jogada); end
      checks++; if (bus.igual !== 1'b0) begin errors++; $display("FAIL cmp_ne got=%b exp=0", bus.igual); end
      bus.zeraR = 1; bus.registrarR = 1; step(); bus.zeraR = 0; bus.registrarR = 0;
      checks++; if (db_jogada !== 4'b0000) begin errors++; $display("FAIL cmp_clear_prio got=%b exp=0000", db_jogada); end
      botoes = 0; step(3);
   endtask

   task automatic test_expansion();
      bus.zera_endereco = 1; bus.zera_limite = 1; step();
      bus.zera_endereco = 0; bus.zera_limite = 0;
      bus.conta_limite = 1; step(2); bus.conta_limite = 0;
      bus.conta_endereco = 1; step(3); bus.conta_endereco = 0;
      checks++; if (db_limite !== 4'd2 || db_endereco !== 4'd3) begin errors++; $display("FAIL exp_setup got=%0d/%0d exp=2/3", db_limite, db_endereco); end
      checks++; if (bus.enderecoIgualLimite !== 1'b0) begin errors++; $display("FAIL exp_eil_before got=%b exp=0", bus.enderecoIgualLimite); end
      checks++; if (db_memoria !== 4'b0010) begin errors++; $display("FAIL exp_mem3_init got=%b exp=0010", db_memoria); end
      botoes = 4'b1000; step(3);
      bus.registra_jogada = 1; step(); bus.registra_jogada = 0;
      bus.conf_leds = 1; #1;
      checks++; if (db_memoria !== 4'b1000) begin errors++; $display("FAIL exp_write got=%b exp=1000", db_memoria); end
      checks++; if (leds !== 4'b1000) begin errors++; $display("FAIL exp_leds got=%b exp=1000", leds); end
      bus.conf_leds = 0;
      bus.conta_limite = 1; step(); bus.conta_limite = 0;
      checks++; if (bus.enderecoIgualLimite !== 1'b1) begin errors++; $display("FAIL exp_eil got=%b exp=1", bus.enderecoIgualLimite); end
      checks++; if (bus.fim_sequencia !== 1'b1) begin errors++; $display("FAIL exp_fim_seq got=%b exp=1", bus.fim_sequencia); end
      botoes = 4'b0100; step(3);
      bus.registra_jogada = 1; bus.conta_endereco = 1; step();
      bus.registra_jogada = 0; bus.conta_endereco = 0;
      checks++; if (db_endereco !== 4'd4 || db_memoria !== 4'b1000) begin errors++; $display("FAIL exp_wr_cnt got=%0d/%b exp=4/1000", db_endereco, db_memoria); end
      bus.conta_endereco = 1; step(15); bus.conta_endereco = 0;
      checks++; if (db_endereco !== 4'd3 || db_memoria !== 4'b0100) begin errors++; $display("FAIL exp_wrap_mem got=%0d/%b exp=3/0100", db_endereco, db_memoria); end
      bus.conta_limite = 1; step(11); bus.conta_limite = 0;
      checks++; if (bus.fim_jogo !== 1'b0) begin errors++; $display("FAIL exp_fim14 got=%b exp=0", bus.fim_jogo); end
      bus.conta_limite = 1; step(); bus.conta_limite = 0;
      checks++; if (db_limite !== 4'd15 || bus.fim_jogo !== 1'b1) begin errors++; $display("FAIL exp_fim_jogo got=%0d/%b exp=15/1", db_limite, bus.fim_jogo); end
      bus.conta_limite = 1; step(); bus.conta_limite = 0;
      checks++; if (db_limite !== 4'd0 || bus.fim_jogo !== 1'b0) begin errors++; $display("FAIL exp_lim_wrap got=%0d/%b exp=0/0", db_limite, bus.fim_jogo); end
      botoes = 0; step(3);
   endtask

   task automatic test_timers();
      bus.zera_s_led = 1; step(); bus.zera_s_led = 0;
      bus.enable_led = 1;
      step(2);
      checks++; if (bus.timeout_led !== 1'b0) begin errors++; $display("FAIL led_early got=%b exp=0", bus.timeout_led); end
      step();
      checks++; if (bus.timeout_led !== 1'b1) begin errors++; $display("FAIL led_rise got=%b exp=1", bus.timeout_led); end
      step(2);
      checks++; if (bus.timeout_led !== 1'b1) begin errors++; $display("FAIL led_hold got=%b exp=1", bus.timeout_led); end
      bus.zera_s_led = 1; step(); bus.zera_s_led = 0;
      checks++; if (bus.timeout_led !== 1'b0) begin errors++; $display("FAIL led_clear_prio got=%b exp=0", bus.timeout_led); end
      step(2);
      checks++; if (bus.timeout_led !== 1'b0) begin errors++; $display("FAIL led_recount got=%b exp=0", bus.timeout_led); end
      step();
      checks++; if (bus.timeout_led !== 1'b1) begin errors++; $display("FAIL led_rerise got=%b exp=1", bus.timeout_led); end
      bus.enable_led = 0;
      bus.zera_s_timeout = 1; step(); bus.zera_s_timeout = 0;
      bus.enable_timeout = 1;
      step(4);
      checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL tmo_early got=%b exp=0", bus.timeout); end
      step();
      checks++; if (bus.timeout !== 1'b1) begin errors++; $display("FAIL tmo_rise got=%b exp=1", bus.timeout); end
      step(3);
      checks++; if (bus.timeout !== 1'b1) begin errors++; $display("FAIL tmo_hold got=%b exp=1", bus.timeout); end
      bus.enable_timeout = 0;
      bus.zera_s_timeout = 1; step(); bus.zera_s_timeout = 0;
      checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL tmo_clear got=%b exp=0", bus.timeout); end
   endtask

   task automatic test_mode();
      chave_timeout = 1;
      bus.registra_modo = 1; step(); bus.registra_modo = 0;
      checks++; if (bus.timeout_habilitado !== 1'b1) begin errors++; $display("FAIL modo_load got=%b exp=1", bus.timeout_habilitado); end
      chave_timeout = 0; step(3);
      checks++; if (bus.timeout_habilitado !== 1'b1) begin errors++; $display("FAIL modo_hold got=%b exp=1", bus.timeout_habilitado); end
      bus.registra_modo = 1; step(); bus.registra_modo = 0;
      checks++; if (bus.timeout_habilitado !== 1'b0) begin errors++; $display("FAIL modo_reload got=%b exp=0", bus.timeout_habilitado); end
      chave_timeout = 1;
      bus.registra_modo = 1; step(); bus.registra_modo = 0;
      bus.zera_modo = 1; bus.registra_modo = 1; step();
      bus.zera_modo = 0; bus.registra_modo = 0;
      checks++; if (bus.timeout_habilitado !== 1'b0) begin errors++; $display("FAIL modo_clear_prio got=%b exp=0", bus.timeout_habilitado); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      clear_cmds();
      botoes = 0;
      chave_timeout = 0;
      reset = 1;
      step(2);
      @(negedge clock) reset = 0;
      step(2);
      test_reset();
      test_button_edge();
      test_compare();
      test_expansion();
      test_timers();
      test_mode();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fluxo_dados.md
# fluxo_dados

Datapath of the memory game, directly downstream of the game FSM: it executes the FSM's one-hot command strobes and returns the status flags that steer it. It holds the sequence memory, address and limit counters, player-move register, mode register, move timeout and LED-phase timers, and the button edge detector. It drives the RGB LED colour bus shown to the player.

## Interface
- `DEPTH`, 16: sequence memory depth; address width is `clog2(DEPTH)`.
- `M_TIMEOUT`, 5000: clock cycles allowed per player move before `timeout`.
- `M_LED`, 1000: clock cycles per LED on phase and per LED off phase.
- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `botoes` in 4: raw player buttons, one-hot colour code.
- `chave_timeout` in 1: mode switch that enables the move timeout.
- `zera_endereco`, `conta_endereco` in 1 each: clear or increment the address counter.
- `zera_limite`, `conta_limite` in 1 each: clear or increment the limit counter.
- `zeraR`, `registrarR` in 1 each: clear or load the move register.
- `zera_modo`, `registra_modo` in 1 each: clear or load the mode register.
- `zera_s_timeout`, `enable_timeout` in 1 each: clear or run the move timer.
- `zera_s_led`, `enable_led` in 1 each: clear or run the LED timer.
- `registra_jogada` in 1: write `botoes_sync` to memory at the current address.
- `conf_leds` in 1: drive the memory word onto `leds`.
- `jogada` out 1: one-cycle pulse on the first button press.
- `igual` out 1: move register equals `mem[endereco]`.
- `enderecoIgualLimite` out 1: `endereco == limite`.
- `fim_sequencia` out 1: identical to `enderecoIgualLimite`.
- `fim_jogo` out 1: `limite == DEPTH-1`.
- `timeout` out 1: move timer expired.
- `timeout_led` out 1: LED timer expired.
- `timeout_habilitado` out 1: registered mode bit.
- `leds` out 4: colour shown to the player.
- `db_endereco` out 4: address counter, for debug.
- `db_limite` out 4: limit counter, for debug.
- `db_jogada` out 4: move register, for debug.
- `db_memoria` out 4: `mem[endereco]`, for debug.

## Operation
- **Counters.** Every counter gives clear priority over count. The address and limit counters wrap from `DEPTH-1` to 0.
- **Button input.** `botoes` passes through a 2-flop synchronizer to give `botoes_sync`. `jogada` = `|botoes_sync & ~|botoes_sync_d`, registered.
- **Move register.** `registrarR` loads `botoes_sync`. Multi-hot or zero values are stored unchanged and simply fail `igual`.
- **Sequence memory.** Register array `mem[DEPTH]` with an asynchronous read.
  - Reset loads `SEQ_INICIAL`. All entries are one-hot and nonzero.
  - `registra_jogada` writes at the next clock edge, with data `botoes_sync` and address `endereco`.
- **Move timer.** Counts 0..`M_TIMEOUT-1` while `enable_timeout` is high and saturates there. `timeout` = (count == `M_TIMEOUT-1`).
- **LED timer.** Counts 0..`M_LED-1` while `enable_led` is high and saturates there. `timeout_led` = (count == `M_LED-1`).
- **Mode register.** `registra_modo` loads `chave_timeout`; `zera_modo` clears it.
- **LED output.** `leds` = `conf_leds ? mem[endereco] : 4'b0000`.
- **Status flags.** All status outputs are combinational decodes of registered state.
- **Reset values.**
  - Counters, timers, move register and mode register are all 0.
  - `jogada`, `timeout`, `timeout_led`, `timeout_habilitado`, `igual`, `fim_jogo` = 0.
  - `enderecoIgualLimite` and `fim_sequencia` = 1.
  - `leds` = 0.
- **Reset mid-game.** Reset restores all of the above immediately and reloads `SEQ_INICIAL`, discarding any words the player has written.

## Timing
- **Button latency.** `jogada` rises 3 clock edges after `botoes` rises. It lasts exactly 1 cycle per press. Holding the button gives no repeat pulse; the button must fall for 1+ synchronized cycle before it re-arms.
- **Register load.** Pulsing `registrarR` in cycle N makes `igual` valid from cycle N+1.
- **Memory write.** A write in cycle N is visible on `db_memoria`/`leds` from cycle N+1.
- **Write-then-count.** A write and `conta_endereco` asserted in the same cycle write at the old address.
- **Move timer.** `timeout` rises exactly `M_TIMEOUT-1` enabled cycles after a clear.
- **LED timer.** `timeout_led` rises exactly `M_LED-1` enabled cycles after a clear.
- **Simultaneous commands.** Clear and enable (or clear and count) in the same cycle: clear wins.

## Structure
- **Package `fluxo_dados_pkg`.** Holds `SEQ_INICIAL` (16 × 4-bit), the colour code constants (`VERMELHO`, `VERDE`, `AZUL`, `AMARELO`) and the default `DEPTH`.
- **Sub-module `contador_m`.** Parameterized mod-M counter: inputs `zera`, `conta`; output `fim` asserted at the terminal count; a saturate/wrap parameter selects behaviour at the terminal count. It is instantiated four times: address, limit, move timer and LED timer.

## Test plan
- **Reset values.** Assert reset mid-count → all outputs take their reset values asynchronously; `db_memoria` = `SEQ_INICIAL[0]`.
- **Button edge.** Press `botoes`=0100 and hold 10 cycles → exactly one `jogada` pulse, 3 edges after the press. Release then press again → a second pulse.
- **Compare.** With `endereco`=0 and `mem[0]`=0001, load 0001 → `igual`=1. Load 0011 → `igual`=0.
- **Expansion.** Set `limite`=2, `endereco`=3, press 1000 with `registra_jogada` asserted → `mem[3]`=1000. Then `conta_limite` → `enderecoIgualLimite`=1. At `limite`=15, `fim_jogo`=1.
- **Timers.** `M_LED`=4: enable from a clear → `timeout_led` rises on the 3rd enabled edge and holds. `zera_s_led` together with `enable_led` → count 0.
- **Mode gating.** `chave_timeout`=1 then `registra_modo` → `timeout_habilitado`=1. Change the switch → the output holds until the next `registra_modo`.
